mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Memory-side responder for the control unit's request outputs: ru_iren_out, ru_dren_out, ru_dwen_out.
- Arbitrates instruction fetch and data load/store onto one RAM port.
- Returns the ihit/dhit pulses that feed ru_ihit_in and ru_dhit_in, plus the load data.
- Sits between the request unit/datapath and the RAM model.

Parameters:
- DPRIO, 1, 1 = data request always wins arbitration in IDLE; 0 = alternate grants when both are pending (last-grant flag).
- TO_CYCLES, 255, watchdog limit in cycles (8-bit counter); used only when MEM_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iren  input  1  instruction read request (from ru_iren_out)
- iaddr  input  32  instruction word address
- dren  input  1  data read request (from ru_dren_out)
- dwen  input  1  data write request (from ru_dwen_out)
- daddr  input  32  data address
- dstore  input  32  store data
- ihit  output  1  one-cycle instruction-complete pulse
- dhit  output  1  one-cycle data-complete pulse
- iload  output  32  fetched instruction; valid when ihit=1
- dload  output  32  load data; valid when dhit=1 and the access was a read
- ram_ren  output  1  RAM read enable
- ram_wen  output  1  RAM write enable
- ram_addr  output  32  RAM address
- ram_store  output  32  RAM write data
- ram_load  input  32  RAM read data
- ram_ready  input  1  RAM access done this cycle
- busy  output  1  state is not IDLE
- err  output  1  sticky watchdog error (constant 0 without the macro)

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE, last_grant=I, wait counter=0, err=0.
  - All outputs 0. Registered iload/dload=0.
- States: IDLE, IACC, DACC.
- IDLE:
  - No RAM enables are driven; no hit is possible in this state.
  - If dren|dwen and (DPRIO=1, or no iren, or last_grant=I): go to DACC.
  - Else if iren: go to IACC.
  - Else: stay in IDLE.
- IACC:
  - Drive ram_ren=1, ram_addr=iaddr.
  - On ram_ready: ihit=1 combinationally that cycle; iload captures ram_load at the clock edge and is also forwarded combinationally in that cycle; last_grant<=I; go to IDLE.
  - If iren drops before ram_ready: abort to IDLE with no hit.
- DACC:
  - ram_addr=daddr.
  - If dwen=1: ram_wen=1, ram_store=dstore. dwen takes precedence if dren and dwen are both 1; ram_ren=0.
  - Else: ram_ren=1.
  - On ram_ready: dhit=1; dload=ram_load for reads, with the same capture/forward rule as iload; dload is unchanged for writes; last_grant<=D; go to IDLE.
  - If dren and dwen both drop: abort to IDLE with no hit.
- No preemption: a data request arriving during IACC waits until the fetch completes or aborts.
- Minimum latency:
  - Request seen in IDLE at cycle N; access runs in cycle N+1.
  - If ram_ready=1 in N+1, the hit is in N+1. A k-cycle RAM gives the hit at N+k.
- Back-to-back:
  - After a hit there is always one IDLE cycle, so the requester may change address or request on the hit edge.
  - A still-asserted request is re-arbitrated in that IDLE cycle.
- ihit and dhit are never high in the same cycle. ram_ren and ram_wen are never both high.
- ram_ready while in IDLE is ignored.
- Address and data inputs are sampled live, not latched. The requester holds them stable until the hit.
- Wait counter:
  - Clears on entry to IACC/DACC; increments each access cycle without ram_ready.
  - Saturates at 255.

Optional Feature:
- MEM_TIMEOUT_EN.
- Defined:
  - If the wait counter reaches TO_CYCLES in IACC/DACC, set err=1 (sticky until nRST) and force the state to IDLE with no hit.
  - The request re-arbitrates on the following cycle.
- Undefined:
  - No timeout; the block waits indefinitely for ram_ready.
  - err is tied to 0 and the counter may be optimized away.

Test Plan:
- Reset: drive nRST=0 mid-DACC with ram_wen=1 -> ram_wen=0, busy=0, dhit=0 immediately and asynchronously; after release the state is IDLE.
- Instruction fetch: iren=1, iaddr=0x00000040, ram_ready asserted 2 cycles after IACC entry with ram_load=0x8C220004 -> ram_ren=1, ram_addr=0x40 during the access; ihit for exactly 1 cycle; iload=0x8C220004.
- Data priority with DPRIO=1: iren=1 and dren=1 (daddr=0x100) together in IDLE -> DACC first, dhit with dload=ram_load; then 1 IDLE cycle; then IACC and ihit.
- Alternation with DPRIO=0: hold iren, dren and dwen high for 4 grants -> grant order D, I, D, I, after reset-time last_grant=I.
- Store with dren=dwen=1, daddr=0x200, dstore=0xDEADBEEF -> ram_wen=1, ram_ren=0, ram_store=0xDEADBEEF; dhit on ram_ready; dload unchanged.
- Abort/timeout:
  - Drop iren mid-IACC -> IDLE next cycle, no ihit.
  - With MEM_TIMEOUT_EN and TO_CYCLES=8, hold ram_ready=0 -> err=1 after 8 access cycles and state returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and RAM-side signals of the memory arbiter.
// slave = arbiter view, master = requester/RAM environment view.
interface mem_arbiter_if;
   logic        iren;
   logic [31:0] iaddr;
   logic        dren;
   logic        dwen;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        ihit;
   logic        dhit;
   logic [31:0] iload;
   logic [31:0] dload;
   logic        ram_ren;
   logic        ram_wen;
   logic [31:0] ram_addr;
   logic [31:0] ram_store;
   logic [31:0] ram_load;
   logic        ram_ready;

   modport slave (
      input  iren, iaddr, dren, dwen,
      input  daddr, dstore,
      input  ram_load, ram_ready,
      output ihit, dhit, iload, dload,
      output ram_ren, ram_wen,
      output ram_addr, ram_store
   );

   modport master (
      output iren, iaddr, dren, dwen,
      output daddr, dstore,
      output ram_load, ram_ready,
      input  ihit, dhit, iload, dload,
      input  ram_ren, ram_wen,
      input  ram_addr, ram_store
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between fetch and load/store.
// Optional watchdog timeout enabled by defining MEM_TIMEOUT_EN.
module mem_arbiter #(
   parameter bit DPRIO     = 1'b1,
   parameter int TO_CYCLES = 255
) (
   input  logic         CLK,
   input  logic         nRST,
   mem_arbiter_if.slave bus,
   output logic         busy,
   output logic         err
);

   typedef enum logic [1:0] {
      IDLE,
      IACC,
      DACC
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        last_d;
   logic        last_nxt;
   logic [31:0] iload_q;
   logic [31:0] dload_q;
   logic        dreq;
   logic        tmo;

   assign dreq = bus.dren | bus.dwen;
   assign busy = (state != IDLE);

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TO_CYCLES);

   logic [7:0] wcnt;
   logic [7:0] wcnt_inc;
   logic       hold;
   logic       err_q;

   assign wcnt_inc = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
   assign tmo  = ~bus.ram_ready & (wcnt_inc >= TO_LIM);
   assign hold = (state == IACC) ? bus.iren : dreq;
   assign err  = err_q;

   // Wait counter: zero while idle, saturating count of stalled cycles
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wcnt <= 8'd0;
      end else if (state == IDLE) begin
         wcnt <= 8'd0;
      end else if (!bus.ram_ready) begin
         wcnt <= wcnt_inc;
      end
   end

   // Sticky error once an access outlives the watchdog limit
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         err_q <= 1'b0;
      end else if (busy && hold && tmo) begin
         err_q <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   // State and last-grant registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         last_d <= 1'b0;
      end else begin
         state  <= state_nxt;
         last_d <= last_nxt;
      end
   end

   // Arbitration, RAM drive and hit generation
   always_comb begin
      state_nxt     = state;
      last_nxt      = last_d;
      bus.ram_ren   = 1'b0;
      bus.ram_wen   = 1'b0;
      bus.ram_addr  = 32'd0;
      bus.ram_store = 32'd0;
      bus.ihit      = 1'b0;
      bus.dhit      = 1'b0;
      unique case (state)
         IDLE: begin
            if (dreq && (DPRIO || !bus.iren || !last_d)) begin
               state_nxt = DACC;
            end else if (bus.iren) begin
               state_nxt = IACC;
            end
         end
         IACC: begin
            bus.ram_ren  = 1'b1;
            bus.ram_addr = bus.iaddr;
            if (!bus.iren) begin
               state_nxt = IDLE;
            end else if (bus.ram_ready) begin
               bus.ihit  = 1'b1;
               last_nxt  = 1'b0;
               state_nxt = IDLE;
            end else if (tmo) begin
               state_nxt = IDLE;
            end
         end
         DACC: begin
            bus.ram_addr = bus.daddr;
            if (bus.dwen) begin
               bus.ram_wen   = 1'b1;
               bus.ram_store = bus.dstore;
            end else begin
               bus.ram_ren = 1'b1;
            end
            if (!dreq) begin
               state_nxt = IDLE;
            end else if (bus.ram_ready) begin
               bus.dhit  = 1'b1;
               last_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (tmo) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Capture returned words; stores leave dload untouched
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         iload_q <= 32'd0;
         dload_q <= 32'd0;
      end else begin
         if (bus.ihit) begin
            iload_q <= bus.ram_load;
         end
         if (bus.dhit && !bus.dwen) begin
            dload_q <= bus.ram_load;
         end
      end
   end

   assign bus.iload = bus.ihit ? bus.ram_load : iload_q;
   assign bus.dload = (bus.dhit && !bus.dwen) ? bus.ram_load : dload_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference for both DPRIO settings.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        sel;
   logic        iren;
   logic [31:0] iaddr;
   logic        dren;
   logic        dwen;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] ram_load;
   logic        ram_ready;
   logic        busy_p1;
   logic        err_p1;
   logic        busy_p0;
   logic        err_p0;

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] ram_mem [logic [31:0]];

   mem_arbiter_if if_p1 ();
   mem_arbiter_if if_p0 ();

   mem_arbiter #(.DPRIO(1'b1), .TO_CYCLES(8)) u_p1 (
      .CLK  (clk),
      .nRST (rst_n),
      .bus  (if_p1),
      .busy (busy_p1),
      .err  (err_p1)
   );

   mem_arbiter #(.DPRIO(1'b0), .TO_CYCLES(8)) u_p0 (
      .CLK  (clk),
      .nRST (rst_n),
      .bus  (if_p0),
      .busy (busy_p0),
      .err  (err_p0)
   );

   assign if_p1.iren      = iren;
   assign if_p1.iaddr     = iaddr;
   assign if_p1.dren      = dren;
   assign if_p1.dwen      = dwen;
   assign if_p1.daddr     = daddr;
   assign if_p1.dstore    = dstore;
   assign if_p1.ram_load  = ram_load;
   assign if_p1.ram_ready = ram_ready;
   assign if_p0.iren      = iren;
   assign if_p0.iaddr     = iaddr;
   assign if_p0.dren      = dren;
   assign if_p0.dwen      = dwen;
   assign if_p0.daddr     = daddr;
   assign if_p0.dstore    = dstore;
   assign if_p0.ram_load  = ram_load;
   assign if_p0.ram_ready = ram_ready;

   logic        o_ihit;
   logic        o_dhit;
   logic [31:0] o_iload;
   logic [31:0] o_dload;
   logic        o_ren;
   logic        o_wen;
   logic [31:0] o_addr;
   logic [31:0] o_store;
   logic        o_busy;
   logic        o_err;

   assign o_ihit  = sel ? if_p1.ihit      : if_p0.ihit;
   assign o_dhit  = sel ? if_p1.dhit      : if_p0.dhit;
   assign o_iload = sel ? if_p1.iload     : if_p0.iload;
   assign o_dload = sel ? if_p1.dload     : if_p0.dload;
   assign o_ren   = sel ? if_p1.ram_ren   : if_p0.ram_ren;
   assign o_wen   = sel ? if_p1.ram_wen   : if_p0.ram_wen;
   assign o_addr  = sel ? if_p1.ram_addr  : if_p0.ram_addr;
   assign o_store = sel ? if_p1.ram_store : if_p0.ram_store;
   assign o_busy  = sel ? busy_p1         : busy_p0;
   assign o_err   = sel ? err_p1          : err_p0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] seed_val(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'hA5A5_5A5A;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return seed_val(a);
   endfunction

   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      if (ram_mem.exists(a)) return ram_mem[a];
      return seed_val(a);
   endfunction

   task automatic clr_in();
      iren      = 1'b0;
      iaddr     = 32'd0;
      dren      = 1'b0;
      dwen      = 1'b0;
      daddr     = 32'd0;
      dstore    = 32'd0;
      ram_load  = 32'd0;
      ram_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clr_in();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic run_rand(input int n);
      int          g;
      int          ng;
      int          lat;
      int          lcnt;
      bit          first;
      bit          lg_d;
      bit          ip;
      bit          dp;
      bit          dwe;
      bit          dre;
      bit          hi;
      bit          hd;
      logic [31:0] li;
      logic [31:0] ld;
      g = 0; first = 0; lg_d = 0;
      lat = 1; lcnt = 0;
      ip = 0; dp = 0; dwe = 0; dre = 0;
      hi = 0; hd = 0;
      li = 32'd0; ld = 32'd0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (hi) ip = 0;
         if (hd) dp = 0;
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1;
            iaddr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
         end
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1;
            dwe = 1'($urandom_range(0, 1));
            dre = dwe ? 1'($urandom_range(0, 1)) : 1'b1;
            daddr = 32'h2000 + 32'($urandom_range(0, 7)) * 4;
            dstore = $urandom;
         end
         iren = ip;
         dren = dp && dre;
         dwen = dp && dwe;
         #1;
         if (o_busy) begin
            lcnt++;
            ram_ready = (lcnt >= lat);
         end else begin
            lcnt = 0;
            lat = $urandom_range(1, 4);
            ram_ready = ($urandom_range(0, 3) == 0);
         end
         ram_load = (ram_ready && o_ren) ? ram_rd(o_addr) : $urandom;
         #1;
         hi = (g == 1) && ram_ready;
         hd = (g == 2) && ram_ready;
         chk("r_busy", 32'(o_busy), 32'(g != 0));
         if (first && g == 1) begin
            chk("r_gnt_i_ren", 32'(o_ren), 32'd1);
            chk("r_gnt_i_wen", 32'(o_wen), 32'd0);
            chk("r_gnt_i_addr", o_addr, iaddr);
         end
         if (first && g == 2) begin
            chk("r_gnt_d_wen", 32'(o_wen), 32'(dwe));
            chk("r_gnt_d_ren", 32'(o_ren), 32'(!dwe));
            chk("r_gnt_d_addr", o_addr, daddr);
            if (dwe) chk("r_gnt_d_store", o_store, dstore);
         end
         chk("r_ihit", 32'(o_ihit), 32'(hi));
         chk("r_dhit", 32'(o_dhit), 32'(hd));
         chk("r_excl", 32'(o_ren & o_wen), 32'd0);
         if (hi) li = ref_rd(iaddr);
         if (hd && !dwe) ld = ref_rd(daddr);
         chk("r_iload", o_iload, li);
         chk("r_dload", o_dload, ld);
         chk("r_err", 32'(o_err), 32'd0);
         if (hd && dwe) ref_mem[daddr] = dstore;
         if (o_wen && ram_ready) ram_mem[o_addr] = o_store;
         if (g == 0) begin
            if ((dren || dwen) && (sel || !iren || !lg_d)) ng = 2;
            else if (iren) ng = 1;
            else ng = 0;
            first = (ng != 0);
         end else begin
            first = 0;
            ng = ram_ready ? 0 : g;
            if (ram_ready) lg_d = (g == 2);
         end
         g = ng;
      end
      @(negedge clk);
      clr_in();
   endtask

   initial begin
      sel = 1'b1;
      rst_n = 1'b0;
      clr_in();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_ihit", 32'(o_ihit), 32'd0);
      chk("rst_dhit", 32'(o_dhit), 32'd0);
      chk("rst_ren", 32'(o_ren), 32'd0);
      chk("rst_wen", 32'(o_wen), 32'd0);
      chk("rst_addr", o_addr, 32'd0);
      chk("rst_iload", o_iload, 32'd0);
      chk("rst_dload", o_dload, 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      rst_n = 1'b1;

      nxt(); iren = 1'b1; iaddr = 32'h40; #1;
      chk("if_idle", 32'(o_busy), 32'd0);
      nxt(); #1;
      chk("if_ren", 32'(o_ren), 32'd1);
      chk("if_addr", o_addr, 32'h40);
      chk("if_nohit1", 32'(o_ihit), 32'd0);
      nxt(); #1;
      chk("if_nohit2", 32'(o_ihit), 32'd0);
      nxt(); ram_ready = 1'b1; ram_load = 32'h8C22_0004; #1;
      chk("if_hit", 32'(o_ihit), 32'd1);
      chk("if_fwd", o_iload, 32'h8C22_0004);
      chk("if_nodhit", 32'(o_dhit), 32'd0);
      nxt(); iren = 1'b0; ram_ready = 1'b0; ram_load = 32'd0; #1;
      chk("if_hit_off", 32'(o_ihit), 32'd0);
      chk("if_after", 32'(o_busy), 32'd0);
      chk("if_reg", o_iload, 32'h8C22_0004);

      nxt(); iren = 1'b1; dren = 1'b1; daddr = 32'h100; #1;
      nxt(); ram_ready = 1'b1; ram_load = 32'h1111_2222; #1;
      chk("pr_d_addr", o_addr, 32'h100);
      chk("pr_d_ren", 32'(o_ren), 32'd1);
      chk("pr_dhit", 32'(o_dhit), 32'd1);
      chk("pr_noihit", 32'(o_ihit), 32'd0);
      chk("pr_dload", o_dload, 32'h1111_2222);
      nxt(); ram_ready = 1'b0; dren = 1'b0; #1;
      chk("pr_gap", 32'(o_busy), 32'd0);
      nxt(); ram_ready = 1'b1; ram_load = 32'h3333_4444; #1;
      chk("pr_i_addr", o_addr, 32'h40);
      chk("pr_ihit", 32'(o_ihit), 32'd1);
      chk("pr_iload", o_iload, 32'h3333_4444);
      nxt(); iren = 1'b0; ram_ready = 1'b0; #1;

      nxt(); dren = 1'b1; dwen = 1'b1; daddr = 32'h200;
      dstore = 32'hDEAD_BEEF; #1;
      nxt(); #1;
      chk("st_wen", 32'(o_wen), 32'd1);
      chk("st_ren", 32'(o_ren), 32'd0);
      chk("st_data", o_store, 32'hDEAD_BEEF);
      chk("st_addr", o_addr, 32'h200);
      nxt(); ram_ready = 1'b1; ram_load = 32'h5555_5555; #1;
      chk("st_dhit", 32'(o_dhit), 32'd1);
      chk("st_dload", o_dload, 32'h1111_2222);
      nxt(); dren = 1'b0; dwen = 1'b0; ram_ready = 1'b0; #1;
      chk("st_dload_reg", o_dload, 32'h1111_2222);

      nxt(); iren = 1'b1; iaddr = 32'h80; #1;
      nxt(); #1;
      chk("ab_busy", 32'(o_busy), 32'd1);
      nxt(); iren = 1'b0; #1;
      chk("ab_nohit", 32'(o_ihit), 32'd0);
      nxt(); #1;
      chk("ab_idle", 32'(o_busy), 32'd0);
      chk("ab_nohit2", 32'(o_ihit), 32'd0);

      nxt(); iren = 1'b1; iaddr = 32'hC0; #1;
      for (int k = 0; k < 8; k++) begin
         nxt(); #1;
         chk("to_wait_busy", 32'(o_busy), 32'd1);
         chk("to_wait_err", 32'(o_err), 32'd0);
      end
      nxt(); #1;
`ifdef MEM_TIMEOUT_EN
      chk("to_idle", 32'(o_busy), 32'd0);
      chk("to_err", 32'(o_err), 32'd1);
      chk("to_nohit", 32'(o_ihit), 32'd0);
      nxt(); #1;
      chk("to_rearb", 32'(o_busy), 32'd1);
      chk("to_sticky", 32'(o_err), 32'd1);
`else
      chk("wt_busy", 32'(o_busy), 32'd1);
      chk("wt_err", 32'(o_err), 32'd0);
      repeat (10) nxt();
      #1;
      chk("wt_busy_long", 32'(o_busy), 32'd1);
`endif
      nxt(); iren = 1'b0; #1;
      nxt(); #1;
      chk("to_drop_idle", 32'(o_busy), 32'd0);

      nxt(); dren = 1'b1; dwen = 1'b1; daddr = 32'h300; #1;
      nxt(); #1;
      chk("ar_wen", 32'(o_wen), 32'd1);
      ram_ready = 1'b1; #1;
      chk("ar_dhit_pre", 32'(o_dhit), 32'd1);
      rst_n = 1'b0; #1;
      chk("ar_wen0", 32'(o_wen), 32'd0);
      chk("ar_busy0", 32'(o_busy), 32'd0);
      chk("ar_dhit0", 32'(o_dhit), 32'd0);
      chk("ar_err0", 32'(o_err), 32'd0);
      clr_in();
      nxt(); rst_n = 1'b1;
      nxt(); #1;
      chk("ar_idle", 32'(o_busy), 32'd0);

      sel = 1'b0;
      do_reset();
      for (int gi = 0; gi < 4; gi++) begin
         nxt(); ram_ready = 1'b0;
         if (gi == 0) begin
            iren = 1'b1; iaddr = 32'h40;
            dren = 1'b1; dwen = 1'b1; daddr = 32'h100;
         end
         #1;
         chk("alt_idle", 32'(o_busy), 32'd0);
         nxt(); ram_ready = 1'b1; ram_load = 32'h0BAD_F00D; #1;
         chk("alt_wen", 32'(o_wen), 32'(gi % 2 == 0));
         chk("alt_ren", 32'(o_ren), 32'(gi % 2 == 1));
         chk("alt_dhit", 32'(o_dhit), 32'(gi % 2 == 0));
         chk("alt_ihit", 32'(o_ihit), 32'(gi % 2 == 1));
      end

      sel = 1'b1;
      do_reset();
      run_rand(400);
      sel = 1'b0;
      do_reset();
      run_rand(400);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
